// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the multiword add sequencer: FSM state encoding,
// default geometry and the index-counter width helper.
package multiword_add_seq_pkg;

  localparam int SLICE_W_DEF    = 8;
  localparam int NUM_SLICES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Slice index width: clog2(n), but never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multiword_add_seq_csa_slice.sv
// Combinational carry-select adder slice: both carry outcomes are computed in
// parallel and the incoming carry only drives the final mux.
module csa_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] res_c0;
  logic [W:0] res_c1;

  assign res_c0 = {1'b0, a} + {1'b0, b};
  assign res_c1 = {1'b0, a} + {1'b0, b} + (W+1)'(1);

  assign {cout, sum} = cin ? res_c1 : res_c0;

endmodule

// File: rtl/multiword_add_seq.sv
// Wide adder built by stepping one shared carry-select slice across the
// operands LSB slice first, with the carry registered between slices.
module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
  parameter int SLICE_W    = SLICE_W_DEF,
  parameter int NUM_SLICES = NUM_SLICES_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SLICE_W*NUM_SLICES-1:0] in_a,
  input  logic [SLICE_W*NUM_SLICES-1:0] in_b,
  input  logic                          in_cin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SLICE_W*NUM_SLICES-1:0] out_sum,
  output logic                          out_cout,
  output logic                          busy
);

  localparam int               IDX_W    = idx_width(NUM_SLICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  state_t state_q, state_d;

  logic [IDX_W-1:0]                    idx_q;
  logic [NUM_SLICES-1:0][SLICE_W-1:0]  a_q, b_q, sum_q;
  logic                                carry_q;
  logic                                cout_q;

  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic               last_slice;
  logic               accept;

  csa_slice #(.W(SLICE_W)) u_slice (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign last_slice = (idx_q == LAST_IDX);
  assign accept     = (state_q == ST_IDLE) && in_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_slice) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the data registers are reset too, because an aborted operation must
  // leave no partial result visible on out_sum/out_cout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      idx_q   <= '0;
      a_q     <= in_a;
      b_q     <= in_b;
      sum_q   <= '0;
      carry_q <= in_cin;
      cout_q  <= 1'b0;
    end else if (state_q == ST_RUN) begin
      sum_q[idx_q] <= slice_sum;
      carry_q      <= slice_cout;
      // Counter parks on the last slice rather than wrapping.
      if (last_slice) cout_q <= slice_cout;
      else            idx_q  <= idx_q + 1'b1;
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;

endmodule
